mat_loader: RTL

MAT_LOADER -- requirements
Module: mat_loader

---
 rtl/mat_loader.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mat_loader.sv
// Purpose : streams IN_W-bit beats into one of two N x N matrices (A or B), MSB-first per element.
// Latency : a beat is written on the edge that accepts it; done/busy change the cycle after the final beat.
// Backpressure: in_ready is high only while loading; no beats are taken in IDLE.
// Ports: clk/rst (async, active-high); in_data/in_valid/in_ready beat stream;
//        sel/start/abort control; busy, done_a, done_b, err status; mem_a/mem_b row-major matrices.
module mat_loader #(
  parameter int N      = 4,
  parameter int ELEM_W = 8,
  parameter int IN_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IN_W-1:0]         in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              sel,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done_a,
  output logic                    done_b,
  output logic                    err,
  output logic [N*N*ELEM_W-1:0]   mem_a,
  output logic [N*N*ELEM_W-1:0]   mem_b
);

  localparam int BEATS = ELEM_W / IN_W;
  localparam int NE    = N * N;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int EW    = $clog2(NE);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t          state;
  logic            tgt_b;      // latched target: 0 = A, 1 = B
  logic [BW-1:0]   beat_cnt;
  logic [EW-1:0]   elem_cnt;

  // Each element is stored as BEATS slices; slice BEATS-1 is the MSB slice,
  // so beat k lands in slice BEATS-1-k.
  logic [NE-1:0][BEATS-1:0][IN_W-1:0] mem_a_q;
  logic [NE-1:0][BEATS-1:0][IN_W-1:0] mem_b_q;

  logic [BW-1:0]   slot;
  logic            last_beat;
  logic            last_elem;
  logic            valid_sel;

  assign slot      = BW'(BEATS - 1) - beat_cnt;
  assign last_beat = (beat_cnt == BW'(BEATS - 1));
  assign last_elem = (elem_cnt == EW'(NE - 1));
  assign valid_sel = (sel == 2'b01) || (sel == 2'b10);

  assign busy     = (state == LOAD);
  assign in_ready = (state == LOAD);
  assign mem_a    = mem_a_q;
  assign mem_b    = mem_b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tgt_b    <= 1'b0;
      beat_cnt <= '0;
      elem_cnt <= '0;
      done_a   <= 1'b0;
      done_b   <= 1'b0;
      err      <= 1'b0;
      mem_a_q  <= '0;
      mem_b_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (valid_sel) begin
              tgt_b    <= sel[1];
              beat_cnt <= '0;
              elem_cnt <= '0;
              err      <= 1'b0;
              if (sel[1]) done_b <= 1'b0;
              else        done_a <= 1'b0;
              state    <= LOAD;
            end else begin
              err <= 1'b1;
            end
          end
        end

        LOAD: begin
          // A restart request mid-load never redirects the load; it only flags.
          if (start) err <= 1'b1;

          // Abort wins over a beat presented in the same cycle.
          if (abort) begin
            state <= IDLE;
          end else if (in_valid) begin
            if (tgt_b) mem_b_q[elem_cnt][slot] <= in_data;
            else       mem_a_q[elem_cnt][slot] <= in_data;

            if (last_beat) begin
              beat_cnt <= '0;
              if (last_elem) begin
                elem_cnt <= '0;
                state    <= IDLE;
                if (tgt_b) done_b <= 1'b1;
                else       done_a <= 1'b1;
              end else begin
                elem_cnt <= elem_cnt + 1'b1;
              end
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
